cmd_sequencer: RTL and testbench
================================

# cmd_sequencer

Host-side command sequencer that sits directly upstream of `RemoteComm` in the Knight's Tour bench and board-level host logic. It buffers a queue of 16-bit Knight commands and issues them one at a time through `RemoteComm`'s `send_cmd`/`cmd_sent` handshake. For each command it waits for `RemoteComm`'s `resp_rdy`/`resp`, checks for the 0xA5 acknowledge, and flags a bad response or a response timeout. This removes hand-sequenced `send_cmd` / `wait4sig` pairs from tests and host logic.

## Interface
Parameters:
- `DEPTH`, 8: command FIFO depth; power of two, 2..64.
- `TIMEOUT_CYC`, 24'd10_000_000: cycles allowed from `cmd_sent` to `resp_rdy`.
- `ACK`, 8'hA5: expected response byte.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `push`  in  1  enqueue `push_cmd` this cycle.
- `push_cmd`  in  16  command word. Format: [15:12] opcode, [11:4] heading, [3:0] squares. Not interpreted by this block.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `cmd`  out  16  command presented to `RemoteComm`.
- `send_cmd`  out  1  one-cycle request to `RemoteComm`.
- `cmd_sent`  in  1  pulse from `RemoteComm`; both bytes transmitted.
- `resp_rdy`  in  1  response byte valid, from `RemoteComm`.
- `resp`  in  8  response byte.
- `busy`  out  1  a command is in flight (state is not IDLE).
- `done_cnt`  out  8  acknowledged commands since reset; wraps at 255→0.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  00 none, 01 bad response, 10 timeout.
- `clr_err`  in  1  clears `err`/`err_code`; re-enables issuing.

## Operation
- Reset values: `full`=0, `empty`=1, `cmd`=0, `send_cmd`=0, `busy`=0, `done_cnt`=0, `err`=0, `err_code`=00. FIFO pointers, timer and state are cleared. Reset mid-command abandons it; a late `cmd_sent`/`resp_rdy` arriving in IDLE is ignored.
- FIFO behaviour:
  - `push` while `full` is dropped; contents are unchanged.
  - Push and pop in the same cycle are both honoured. When `full` is also set, the push succeeds only if the pop occurs that cycle.
- State machine IDLE → SEND → WAIT_SENT → WAIT_RESP → IDLE:
  - IDLE: if `!empty && !err`, pop the head into `cmd` and go to SEND.
  - SEND: drive `send_cmd`=1 for exactly this cycle; go to WAIT_SENT.
  - WAIT_SENT: hold until `cmd_sent`. The timer is cleared, then go to WAIT_RESP. There is no timeout here; UART transmit time is bounded by `RemoteComm`.
  - WAIT_RESP: the timer increments each cycle.
    - `resp_rdy` with `resp==ACK`: `done_cnt`+1, go to IDLE.
    - `resp_rdy` with `resp!=ACK`: `err`=1, `err_code`=01, go to IDLE.
    - Timer reaches `TIMEOUT_CYC-1` without `resp_rdy`: `err`=1, `err_code`=10, go to IDLE.
    - `resp_rdy` in the same cycle as the timer limit: the response wins.
- While `err`=1, no new command is issued; queued commands are retained and `push` still works.
- `clr_err` clears the error next cycle. If it coincides with a new error, the new error wins.
- `cmd` holds its value until the next pop.

## Timing
- Push into an empty FIFO while IDLE:
  - `empty` falls 1 cycle later.
  - Pop and entry into SEND happen on the following edge.
  - `send_cmd` is high 2 cycles after the `push` edge.
- `cmd` is valid on the same cycle as `send_cmd` and every cycle after until the next pop.
- `resp_rdy` → IDLE and `done_cnt` update on the same edge. The next `send_cmd` follows 2 cycles later when the FIFO is non-empty.
- Back-to-back throughput is one command per round trip. There is never more than one command outstanding.
- `busy` is registered: high from the SEND edge through the edge that returns to IDLE.

## Structure
- Shared package `ktour_pkg`:
  - state enum `seq_state_t`;
  - `ERR_NONE`/`ERR_RESP`/`ERR_TIMEOUT` constants;
  - opcode constants: `OP_CAL`=4'h0, `OP_MOVE`=4'h2, `OP_MOVE_FAN`=4'h3;
  - heading constants: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- One sub-module, `cmd_fifo`: parameterized sync FIFO, 16-bit × `DEPTH`. Pointers carry one extra bit for full/empty detection; no first-word fall-through.
- Sequencer FSM, timer and counters are in the top module.

## Test plan
- Reset with `rst_n` low 2 cycles → all outputs at reset values; `cmd_sent`/`resp_rdy` pulses during reset cause no state change.
- Push 16'h0000, 16'h2001, 16'h23F2; stub replies 8'hA5 to each → three `send_cmd` pulses carrying those words in order; `done_cnt`=3; `empty`=1; `err`=0.
- `DEPTH`=4: push 6 words while the stub never responds → `full`=1 after 4 accepted words (the first is popped, so 5 are accepted in total); the 6th is dropped.
- Stub replies 8'h5A to the first command → `err`=1, `err_code`=01; second queued command not issued; `clr_err` → second command issued within 2 cycles.
- `TIMEOUT_CYC`=100; `cmd_sent` given, no `resp_rdy` → `err_code`=10 exactly 100 cycles after `cmd_sent`. Repeat with `resp_rdy`=A5 on the limit cycle → no error, `done_cnt`+1.
- Assert `rst_n` low during WAIT_RESP, then send a late `resp_rdy` → stays IDLE; `done_cnt`=0; FIFO empty.

Source files
------------

// File: rtl/ktour_pkg.sv
// Shared Knight's Tour host definitions: sequencer states, error codes and
// command-word field constants.
package ktour_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_SEND      = 2'd1,
        SEQ_WAIT_SENT = 2'd2,
        SEQ_WAIT_RESP = 2'd3
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RESP    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [3:0] OP_CAL      = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    // Command word layout: [15:12] opcode, [11:4] heading, [3:0] squares.
    function automatic logic [15:0] make_cmd(input logic [3:0] op, input logic [7:0] heading,
                                             input logic [3:0] squares);
        return {op, heading, squares};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a counter. Read data is registered on pop.
module cmd_fifo
    import ktour_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A push into a full FIFO only lands if a pop frees a slot the same cycle.
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign rdata = rdata_q;

    // Pointer and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_rd) begin
                rptr_q  <= rptr_q + 1'b1;
                rdata_q <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Host-side command sequencer in front of RemoteComm: queues 16-bit Knight
// commands, issues them one at a time and checks each for the ACK byte.
module cmd_sequencer
    import ktour_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
    parameter logic [7:0]  ACK         = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_cmd,
    output logic        full,
    output logic        empty,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic [7:0]  done_cnt,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        clr_err
);

    localparam logic [1:0] IDLE      = SEQ_IDLE;
    localparam logic [1:0] SEND      = SEQ_SEND;
    localparam logic [1:0] WAIT_SENT = SEQ_WAIT_SENT;
    localparam logic [1:0] WAIT_RESP = SEQ_WAIT_RESP;

    localparam logic [23:0] TIMER_LIMIT = TIMEOUT_CYC - 24'd1;

    logic [1:0]  state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        send_q, send_d;
    logic        busy_q, busy_d;
    logic        pop;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (cmd),
        .full  (full),
        .empty (empty)
    );

    // Next-state logic for the FSM, response timer, ack counter and error flag.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        send_d  = 1'b0;
        pop     = 1'b0;

        // Clear first so an error raised below in the same cycle takes priority.
        if (clr_err) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end

        case (state_q)
            IDLE: begin
                if (!empty && !err_q) begin
                    pop     = 1'b1;
                    send_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (cmd_sent) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + 24'd1;
                // A response on the limit cycle beats the timeout.
                if (resp_rdy) begin
                    state_d = IDLE;
                    if (resp == ACK) begin
                        done_d = done_q + 8'd1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_RESP;
                    end
                end else if (timer_q == TIMER_LIMIT) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
        end
    end

    assign send_cmd = send_q;
    assign busy     = busy_q;
    assign done_cnt = done_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer with a RemoteComm stub driven from tasks.
module tb_cmd_sequencer;
    import ktour_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [15:0] push_cmd = '0;
    logic        full;
    logic        empty;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        busy;
    logic [7:0]  done_cnt;
    logic        err;
    logic [1:0]  err_code;
    logic        clr_err = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          send_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_done = '0;

    cmd_sequencer #(
        .DEPTH       (4),
        .TIMEOUT_CYC (24'd100),
        .ACK         (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_cmd (push_cmd),
        .full     (full),
        .empty    (empty),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done_cnt (done_cnt),
        .err      (err),
        .err_code (err_code),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (send_cmd === 1'b1) send_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    // All stimulus changes and samples happen at the falling edge.
    task automatic push_word(input logic [15:0] w, input bit accept);
        push = 1'b1;
        push_cmd = w;
        if (accept) exp_q.push_back(w);
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_send(input string name);
        bit found = 1'b0;
        logic [15:0] want;
        for (int i = 0; i < 20; i++) begin
            if (send_cmd === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_send: send_cmd=%b want 1 within 20 cycles", name, send_cmd);
        end else begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if (cmd !== want) begin
                bad++;
                $display("FAIL %s_cmd: cmd=%h want %h", name, cmd, want);
            end
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy: busy=%b want 1", name, busy);
        end
    endtask

    // From the send cycle (or any WAIT_SENT cycle): give cmd_sent, end at WAIT_RESP entry.
    task automatic issue_sent(input string name);
        @(negedge clk);
        total++;
        if (send_cmd !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: send_cmd=%b want 0", name, send_cmd);
        end
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
    endtask

    task automatic respond(input string name, input logic [7:0] r, input int delay);
        repeat (delay) @(negedge clk);
        resp_rdy = 1'b1;
        resp = r;
        @(negedge clk);
        resp_rdy = 1'b0;
        if (r == 8'hA5) exp_done++;
        total++;
        if (done_cnt !== exp_done) begin
            bad++;
            $display("FAIL %s_done: done_cnt=%0d want %0d", name, done_cnt, exp_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_sent = 1'b1;
        resp_rdy = 1'b1;
        resp = 8'hA5;
        @(negedge clk);
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = '0;
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: %b want 0", full); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: %b want 1", empty); end
        total++; if (cmd !== 16'h0) begin bad++; $display("FAIL rst_cmd: %h want 0000", cmd); end
        total++;
        if (send_cmd !== 1'b0) begin bad++; $display("FAIL rst_send: %b want 0", send_cmd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: %b want 0", busy); end
        total++;
        if (done_cnt !== 8'd0) begin bad++; $display("FAIL rst_done: %0d want 0", done_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: %b want 0", err); end
        total++;
        if (err_code !== ERR_NONE) begin bad++; $display("FAIL rst_code: %b want 00", err_code); end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || send_cnt != 0) begin
            bad++;
            $display("FAIL rst_quiet: busy=%b sends=%0d want 0/0", busy, send_cnt);
        end
    endtask

    task automatic test_basic();
        logic [15:0] w0 = make_cmd(OP_CAL, HEAD_N, 4'h0);
        logic [15:0] w1 = make_cmd(OP_MOVE, HEAD_N, 4'h1);
        logic [15:0] w2 = make_cmd(OP_MOVE, HEAD_W, 4'h2);
        push_word(w0, 1'b1);
        total++;
        if (empty !== 1'b0 || send_cmd !== 1'b0) begin
            bad++;
            $display("FAIL basic_lat1: empty=%b send=%b want 0/0", empty, send_cmd);
        end
        @(negedge clk);
        total++;
        if (send_cmd !== 1'b1) begin
            bad++;
            $display("FAIL basic_lat2: send_cmd=%b want 1", send_cmd);
        end
        wait_send("basic0");
        push_word(w1, 1'b1);
        push_word(w2, 1'b1);
        issue_sent("basic0");
        respond("basic0", 8'hA5, 3);
        @(negedge clk);
        total++;
        if (send_cmd !== 1'b1) begin
            bad++;
            $display("FAIL basic_b2b: send_cmd=%b want 1 two cycles after resp", send_cmd);
        end
        wait_send("basic1");
        issue_sent("basic1");
        respond("basic1", 8'hA5, 0);
        wait_send("basic2");
        issue_sent("basic2");
        respond("basic2", 8'hA5, 5);
        total++;
        if (done_cnt !== 8'd3 || empty !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: done=%0d empty=%b err=%b want 3/1/0", done_cnt, empty, err);
        end
    endtask

    task automatic test_full();
        logic [15:0] w;
        int sc;
        for (int i = 0; i < 6; i++) begin
            w = 16'h3000 + 16'(i);
            push_word(w, i < 5);
            if (i == 3) begin
                total++;
                if (full !== 1'b0) begin bad++; $display("FAIL full_early: full=%b want 0", full); end
            end
            if (i >= 4) begin
                total++;
                if (full !== 1'b1) begin
                    bad++;
                    $display("FAIL full_set%0d: full=%b want 1", i, full);
                end
            end
        end
        w = exp_q.pop_front();
        total++;
        if (cmd !== w || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_head: cmd=%h busy=%b want %h/1", cmd, busy, w);
        end
        issue_sent("full0");
        respond("full0", 8'hA5, 1);
        for (int i = 1; i < 5; i++) begin
            wait_send("fullq");
            issue_sent("fullq");
            respond("fullq", 8'hA5, 1);
        end
        sc = send_cnt;
        repeat (6) @(negedge clk);
        total++;
        if (send_cnt != sc || empty !== 1'b1) begin
            bad++;
            $display("FAIL full_drop: extra_sends=%0d empty=%b want 0/1", send_cnt - sc, empty);
        end
    endtask

    task automatic test_bad_resp();
        int sc;
        push_word(make_cmd(OP_MOVE_FAN, HEAD_S, 4'h3), 1'b1);
        push_word(make_cmd(OP_MOVE, HEAD_E, 4'h1), 1'b1);
        wait_send("bad_a");
        issue_sent("bad_a");
        respond("bad_a", 8'h5A, 2);
        total++;
        if (err !== 1'b1 || err_code !== ERR_RESP) begin
            bad++;
            $display("FAIL bad_flag: err=%b code=%b want 1/01", err, err_code);
        end
        sc = send_cnt;
        push_word(make_cmd(OP_MOVE, HEAD_W, 4'h5), 1'b1);
        repeat (10) @(negedge clk);
        total++;
        if (send_cnt != sc || empty !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL bad_hold: sends=%0d empty=%b err=%b want 0/0/1",
                     send_cnt - sc, empty, err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (err !== 1'b0 || err_code !== ERR_NONE) begin
            bad++;
            $display("FAIL bad_clr: err=%b code=%b want 0/00", err, err_code);
        end
        @(negedge clk);
        total++;
        if (send_cmd !== 1'b1) begin
            bad++;
            $display("FAIL bad_resume: send_cmd=%b want 1", send_cmd);
        end
        wait_send("bad_b");
        issue_sent("bad_b");
        respond("bad_b", 8'hA5, 1);
        wait_send("bad_c");
        issue_sent("bad_c");
        respond("bad_c", 8'hA5, 1);
    endtask

    task automatic test_timeout();
        push_word(make_cmd(OP_MOVE, HEAD_N, 4'h7), 1'b1);
        wait_send("to_a");
        issue_sent("to_a");
        repeat (99) @(negedge clk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL to_early: err=%b want 0", err); end
        @(negedge clk);
        total++;
        if (err !== 1'b1 || err_code !== ERR_TIMEOUT || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_flag: err=%b code=%b busy=%b want 1/10/0", err, err_code, busy);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        push_word(make_cmd(OP_MOVE, HEAD_S, 4'h2), 1'b1);
        wait_send("to_b");
        issue_sent("to_b");
        repeat (99) @(negedge clk);
        resp_rdy = 1'b1;
        resp = 8'hA5;
        @(negedge clk);
        resp_rdy = 1'b0;
        exp_done++;
        total++;
        if (err !== 1'b0 || done_cnt !== exp_done || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_limit: err=%b done=%0d busy=%b want 0/%0d/0",
                     err, done_cnt, busy, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        push_word(make_cmd(OP_MOVE, HEAD_E, 4'h4), 1'b1);
        push_word(make_cmd(OP_MOVE, HEAD_W, 4'h6), 1'b1);
        wait_send("mid");
        issue_sent("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_done = '0;
        sc = send_cnt;
        cmd_sent = 1'b1;
        resp_rdy = 1'b1;
        resp = 8'hA5;
        @(negedge clk);
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done_cnt !== exp_done || empty !== 1'b1) begin
            bad++;
            $display("FAIL mid_state: busy=%b done=%0d empty=%b want 0/0/1",
                     busy, done_cnt, empty);
        end
        total++;
        if (send_cnt != sc || err !== 1'b0 || cmd !== 16'h0) begin
            bad++;
            $display("FAIL mid_quiet: sends=%0d err=%b cmd=%h want 0/0/0000",
                     send_cnt - sc, err, cmd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_bad_resp();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
